// File: rtl/icc_pkg.sv
// ----------------------------------------------------------------------------
// icc_pkg
// Shared types and constants for the ICC link framer (RX and TX sides).
//   state_e        : frame sync FSM states (HUNT/VERIFY/LOCKED), 2-bit encoded
//   COMMA_DEFAULT  : comma word marking the start of every frame
//   K_ALL          : rxcharisk pattern of a full K word (both bytes K)
//   sat_inc()      : saturating increment for counters up to CNT_MAXW bits
// ----------------------------------------------------------------------------
package icc_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam logic [15:0] COMMA_DEFAULT = 16'h5cbc;
    localparam logic [1:0]  K_ALL         = 2'b11;
    localparam int          CNT_MAXW      = 32;

    // Increment v, holding at all-ones of a w-bit counter (w <= CNT_MAXW).
    // Callers zero-extend into CNT_MAXW and truncate the result back.
    function automatic logic [CNT_MAXW-1:0] sat_inc(input logic [CNT_MAXW-1:0] v,
                                                    input int w);
        logic [CNT_MAXW:0] lim;
        lim = ({{CNT_MAXW{1'b0}}, 1'b1} << w) - {{CNT_MAXW{1'b0}}, 1'b1};
        return (v == lim[CNT_MAXW-1:0]) ? v : v + {{(CNT_MAXW-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/icc_rx_frame_sync_if.sv
// ----------------------------------------------------------------------------
// icc_rx_frame_sync_if
// Word stream into and out of the RX framer.
//   rxdata/rxcharisk/rxstb : raw words from the GT wrapper
//   dout/dout_stb          : aligned words, one clk later
//   sof/word_idx           : frame start flag and in-frame index of dout
// Modports: master = GT side source / downstream sink, slave = framer.
// ----------------------------------------------------------------------------
interface icc_rx_frame_sync_if #(
    parameter int DWIDTH    = 16,
    parameter int FRAME_LEN = 32
);
    localparam int IDXW = $clog2(FRAME_LEN);

    logic [DWIDTH-1:0]   rxdata;
    logic [DWIDTH/8-1:0] rxcharisk;
    logic                rxstb;
    logic [DWIDTH-1:0]   dout;
    logic                dout_stb;
    logic                sof;
    logic [IDXW-1:0]     word_idx;

    modport master (
        output rxdata, rxcharisk, rxstb,
        input  dout, dout_stb, sof, word_idx
    );

    modport slave (
        input  rxdata, rxcharisk, rxstb,
        output dout, dout_stb, sof, word_idx
    );
endinterface

// File: rtl/icc_seq_check.sv
// ----------------------------------------------------------------------------
// icc_seq_check
// Checks that successive data words form an incrementing (mod 2^DWIDTH)
// sequence. The first word after a flush only seeds the reference; a
// mismatch pulses seq_err, bumps the saturating counter and reseeds.
//   clk, reset   : clock, synchronous active-high reset
//   stb          : word is a data word to be checked (framer is locked)
//   word         : the data word
//   flush        : invalidate the seed (loss of lock)
//   seq_err      : registered one-cycle mismatch pulse
//   seq_err_cnt  : saturating mismatch count
// ----------------------------------------------------------------------------
module icc_seq_check
    import icc_pkg::*;
#(
    parameter int DWIDTH  = 16,
    parameter int ERRCNTW = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stb,
    input  logic [DWIDTH-1:0]  word,
    input  logic               flush,
    output logic               seq_err,
    output logic [ERRCNTW-1:0] seq_err_cnt
);

    logic               valid_q, valid_d;
    logic [DWIDTH-1:0]  prev_q, prev_d;
    logic               err_q, err_d;
    logic [ERRCNTW-1:0] cnt_q, cnt_d;

    always_comb begin
        valid_d = valid_q;
        prev_d  = prev_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        if (stb) begin
            // Every checked word becomes the new reference, so a mismatch
            // reseeds from the received value.
            prev_d  = word;
            valid_d = 1'b1;
            if (valid_q && (word != prev_q + DWIDTH'(1))) begin
                err_d = 1'b1;
                cnt_d = ERRCNTW'(sat_inc(CNT_MAXW'(cnt_q), ERRCNTW));
            end
        end
        // Flush wins over seeding, but an error on the same word still counts.
        if (flush) valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            prev_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            prev_q  <= prev_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign seq_err     = err_q;
    assign seq_err_cnt = cnt_q;

endmodule

// File: rtl/icc_rx_frame_sync.sv
// ----------------------------------------------------------------------------
// icc_rx_frame_sync
// RX framer behind the ICC GT wrapper. Hunts for the comma, verifies it
// recurs every FRAME_LEN words, holds lock until UNLOCK_FRAMES consecutive
// bad frames, and forwards words tagged with their in-frame index.
//   clk, reset     : RX user clock, synchronous active-high reset
//   bus (slave)    : rxdata/rxcharisk/rxstb in, dout/dout_stb/sof/word_idx out
//   locked, state  : FSM status (0 HUNT, 1 VERIFY, 2 LOCKED)
//   frame_err_cnt  : saturating count of bad frames while locked
//   seq_err(_cnt)  : data sequence mismatch pulse and saturating count
// All state advances only on rxstb; outputs lag the input word by one clk.
// ----------------------------------------------------------------------------
module icc_rx_frame_sync
    import icc_pkg::*;
#(
    parameter int                DWIDTH        = 16,
    parameter int                FRAME_LEN     = 32,
    parameter logic [DWIDTH-1:0] COMMA         = DWIDTH'(COMMA_DEFAULT),
    parameter int                LOCK_FRAMES   = 4,
    parameter int                UNLOCK_FRAMES = 3,
    parameter int                ERRCNTW       = 16
) (
    input  logic               clk,
    input  logic               reset,
    icc_rx_frame_sync_if.slave bus,
    output logic               locked,
    output logic [1:0]         state,
    output logic [ERRCNTW-1:0] frame_err_cnt,
    output logic               seq_err,
    output logic [ERRCNTW-1:0] seq_err_cnt
);

    localparam int IDXW  = $clog2(FRAME_LEN);
    localparam int KBITS = DWIDTH / 8;
    localparam int GW    = $clog2(LOCK_FRAMES) + 1;
    localparam int BW    = $clog2(UNLOCK_FRAMES) + 1;

    state_e             state_q, state_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic [GW-1:0]      good_q, good_d;
    logic [BW-1:0]      badrun_q, badrun_d;
    logic               bad_q, bad_d;
    logic [ERRCNTW-1:0] ferr_q, ferr_d;
    logic [DWIDTH-1:0]  dout_q, dout_d;
    logic               dout_stb_q, dout_stb_d;
    logic               sof_q, sof_d;
    logic [IDXW-1:0]    word_idx_q, word_idx_d;

    logic               is_comma, is_kerr, is_data;
    logic               seq_stb, seq_flush;
    logic [GW-1:0]      good_inc;
    logic [BW-1:0]      badrun_inc;

    assign is_comma   = (bus.rxcharisk == KBITS'(K_ALL)) && (bus.rxdata == COMMA);
    assign is_data    = (bus.rxcharisk == '0);
    // Any other K pattern means the byte lanes are misaligned.
    assign is_kerr    = !is_data && !is_comma;
    assign good_inc   = good_q + GW'(1);
    assign badrun_inc = badrun_q + BW'(1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        good_d     = good_q;
        badrun_d   = badrun_q;
        bad_d      = bad_q;
        ferr_d     = ferr_q;
        dout_d     = dout_q;
        dout_stb_d = 1'b0;
        sof_d      = 1'b0;
        word_idx_d = word_idx_q;
        seq_stb    = 1'b0;
        seq_flush  = 1'b0;

        if (bus.rxstb) begin
            dout_d     = bus.rxdata;
            dout_stb_d = 1'b1;
            idx_d      = idx_q + IDXW'(1);
            word_idx_d = idx_q;

            case (state_q)
                ST_HUNT: begin
                    word_idx_d = '0;
                    idx_d      = '0;
                    if (is_comma) begin
                        state_d = ST_VERIFY;
                        idx_d   = IDXW'(1);
                        good_d  = '0;
                    end
                end

                ST_VERIFY: begin
                    if (is_kerr) begin
                        state_d = ST_HUNT;
                        idx_d   = '0;
                    end else if (idx_q == '0) begin
                        if (is_comma) begin
                            good_d = good_inc;
                            // The comma that opened VERIFY is frame 0.
                            if (good_inc == GW'(LOCK_FRAMES - 1)) begin
                                state_d  = ST_LOCKED;
                                bad_d    = 1'b0;
                                badrun_d = '0;
                            end
                        end else begin
                            state_d = ST_HUNT;
                            idx_d   = '0;
                        end
                    end else if (is_comma) begin
                        // Comma off-position: restart the frame on this word.
                        idx_d      = IDXW'(1);
                        good_d     = '0;
                        word_idx_d = '0;
                    end
                end

                ST_LOCKED: begin
                    seq_stb = is_data;
                    if (idx_q == '0) begin
                        sof_d = is_comma;
                        bad_d = 1'b0;
                        // Frame verdict: anything flagged so far, or a missing comma.
                        if (bad_q || !is_comma) begin
                            ferr_d = ERRCNTW'(sat_inc(CNT_MAXW'(ferr_q), ERRCNTW));
                            if (badrun_inc == BW'(UNLOCK_FRAMES)) begin
                                state_d   = ST_HUNT;
                                badrun_d  = '0;
                                idx_d     = '0;
                                seq_flush = 1'b1;
                            end else begin
                                badrun_d = badrun_inc;
                            end
                        end else begin
                            badrun_d = '0;
                        end
                    end else if (is_comma || is_kerr) begin
                        bad_d = 1'b1;
                    end
                end

                default: begin
                    state_d = ST_HUNT;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_HUNT;
            idx_q      <= '0;
            good_q     <= '0;
            badrun_q   <= '0;
            bad_q      <= 1'b0;
            ferr_q     <= '0;
            dout_q     <= '0;
            dout_stb_q <= 1'b0;
            sof_q      <= 1'b0;
            word_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            good_q     <= good_d;
            badrun_q   <= badrun_d;
            bad_q      <= bad_d;
            ferr_q     <= ferr_d;
            dout_q     <= dout_d;
            dout_stb_q <= dout_stb_d;
            sof_q      <= sof_d;
            word_idx_q <= word_idx_d;
        end
    end

    icc_seq_check #(
        .DWIDTH (DWIDTH),
        .ERRCNTW(ERRCNTW)
    ) u_seq (
        .clk        (clk),
        .reset      (reset),
        .stb        (seq_stb),
        .word       (bus.rxdata),
        .flush      (seq_flush),
        .seq_err    (seq_err),
        .seq_err_cnt(seq_err_cnt)
    );

    assign bus.dout      = dout_q;
    assign bus.dout_stb  = dout_stb_q;
    assign bus.sof       = sof_q;
    assign bus.word_idx  = word_idx_q;
    assign state         = state_q;
    assign locked        = (state_q == ST_LOCKED);
    assign frame_err_cnt = ferr_q;

endmodule

// File: tb/tb_icc_rx_frame_sync.sv
// ----------------------------------------------------------------------------
// tb_icc_rx_frame_sync
// Scenario tasks drive a framed word stream; each driven word pushes its
// expected dout/word_idx/sof/seq_err to a queue that is popped when the
// registered output appears one clk later.
// ----------------------------------------------------------------------------
module tb_icc_rx_frame_sync;
    import icc_pkg::*;

    localparam int DW = 16;
    localparam int FL = 32;
    localparam int EW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          locked;
    logic [1:0]    state;
    logic [EW-1:0] frame_err_cnt;
    logic          seq_err;
    logic [EW-1:0] seq_err_cnt;

    icc_rx_frame_sync_if #(.DWIDTH(DW), .FRAME_LEN(FL)) bus ();

    icc_rx_frame_sync #(
        .DWIDTH(DW), .FRAME_LEN(FL), .COMMA(16'h5cbc),
        .LOCK_FRAMES(4), .UNLOCK_FRAMES(3), .ERRCNTW(EW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .locked       (locked),
        .state        (state),
        .frame_err_cnt(frame_err_cnt),
        .seq_err      (seq_err),
        .seq_err_cnt  (seq_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [4:0]  idx;
        logic        sof;
        logic        seq;
    } exp_t;

    exp_t        exp_q[$];
    int          checks;
    int          failures;
    int          wn;    // words sent since reset
    int          anc;   // word number of the current frame anchor
    logic [15:0] dv;    // next data value of the incrementing stream

    function automatic logic [4:0] relidx();
        return 5'((wn - anc) % FL);
    endfunction

    task automatic send(input logic [15:0] d, input logic [1:0] k,
                        input logic [4:0] eidx, input logic esof, input logic eseq);
        exp_t e;
        exp_t g;
        e = '{d: d, idx: eidx, sof: esof, seq: eseq};
        exp_q.push_back(e);
        bus.rxdata    = d;
        bus.rxcharisk = k;
        bus.rxstb     = 1'b1;
        @(posedge clk);
        #1;
        bus.rxstb = 1'b0;
        g = exp_q.pop_front();
        checks++;
        if (bus.dout_stb !== 1'b1 || bus.dout !== g.d || bus.word_idx !== g.idx ||
            bus.sof !== g.sof || seq_err !== g.seq) begin
            failures++;
            $display("FAIL word %0d: got stb=%b dout=%h idx=%0d sof=%b seq_err=%b, want stb=1 dout=%h idx=%0d sof=%b seq_err=%b",
                     wn, bus.dout_stb, bus.dout, bus.word_idx, bus.sof, seq_err,
                     g.d, g.idx, g.sof, g.seq);
        end
    endtask

    task automatic idle();
        bus.rxstb = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.dout_stb !== 1'b0 || bus.sof !== 1'b0 || seq_err !== 1'b0) begin
            failures++;
            $display("FAIL idle: got stb=%b sof=%b seq_err=%b, want all 0",
                     bus.dout_stb, bus.sof, seq_err);
        end
    endtask

    task automatic send_d(input logic [15:0] d, input logic [1:0] k, input logic eseq);
        send(d, k, relidx(), 1'b0, eseq);
        wn++;
    endtask

    // n words of the framed stream; commas on idx 0 unless drop is set,
    // sof expected on in-position commas from word sof_from on.
    task automatic stream(input int n, input int sof_from, input bit gaps, input bit drop);
        for (int i = 0; i < n; i++) begin
            logic [4:0] rel;
            rel = relidx();
            if (gaps)
                for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) idle();
            if (rel == 5'd0 && !drop) begin
                send(16'h5cbc, 2'b11, rel, (wn >= sof_from), 1'b0);
            end else begin
                send(dv, 2'b00, rel, 1'b0, 1'b0);
                dv++;
            end
            wn++;
        end
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.rxstb     = 1'b0;
        bus.rxdata    = '0;
        bus.rxcharisk = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wn    = 0;
        anc   = 0;
        dv    = 16'h0100;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.dout, bus.dout_stb, bus.sof, bus.word_idx} !== '0) begin
            failures++;
            $display("FAIL reset_bus: got dout=%h stb=%b sof=%b idx=%0d, want 0",
                     bus.dout, bus.dout_stb, bus.sof, bus.word_idx);
        end
        checks++;
        if ({locked, state, frame_err_cnt, seq_err, seq_err_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_status: got locked=%b state=%0d ferr=%0d seq_err=%b serr=%0d, want 0",
                     locked, state, frame_err_cnt, seq_err, seq_err_cnt);
        end
    endtask

    task automatic test_clean(input bit gaps);
        do_reset();
        stream(96, 128, gaps, 1'b0);
        checks++;
        if (locked !== 1'b0 || state !== 2'd1) begin
            failures++;
            $display("FAIL clean_prelock gaps=%0d: got locked=%b state=%0d, want 0/1", gaps, locked, state);
        end
        stream(1, 128, gaps, 1'b0);
        checks++;
        if (locked !== 1'b1 || state !== 2'd2) begin
            failures++;
            $display("FAIL clean_lock gaps=%0d: got locked=%b state=%0d, want 1/2", gaps, locked, state);
        end
        stream(95, 128, gaps, 1'b0);
        checks++;
        if (seq_err_cnt !== 16'd0 || frame_err_cnt !== 16'd0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL clean_errs gaps=%0d: got serr=%0d ferr=%0d locked=%b, want 0/0/1",
                     gaps, seq_err_cnt, frame_err_cnt, locked);
        end
    endtask

    task automatic test_drop_commas();
        int exp_err[6] = '{1, 2, 2, 3, 4, 5};
        do_reset();
        stream(160, 128, 1'b0, 1'b0);
        for (int f = 0; f < 6; f++) begin
            stream(1, 128, 1'b0, (f != 2));
            checks++;
            if (frame_err_cnt !== 16'(exp_err[f]) || locked !== ((f < 5) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL drop_frame%0d: got ferr=%0d locked=%b, want %0d/%0d",
                         f, frame_err_cnt, locked, exp_err[f], (f < 5));
            end
            if (f < 5) stream(31, 128, 1'b0, 1'b0);
        end
        checks++;
        if (state !== 2'd0 || seq_err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL drop_unlock: got state=%0d serr=%0d, want 0/0", state, seq_err_cnt);
        end
        // Back in HUNT: data words report index 0.
        send(dv, 2'b00, 5'd0, 1'b0, 1'b0);
        send(dv + 16'd1, 2'b00, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reanchor();
        do_reset();
        stream(71, 100000, 1'b0, 1'b0);
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("FAIL reanchor_verify: got state=%0d, want 1", state);
        end
        anc = 71;   // comma placed at idx 7
        stream(96, 199, 1'b0, 1'b0);
        checks++;
        if (locked !== 1'b0 || state !== 2'd1) begin
            failures++;
            $display("FAIL reanchor_prelock: got locked=%b state=%0d, want 0/1", locked, state);
        end
        stream(1, 199, 1'b0, 1'b0);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL reanchor_lock: got locked=%b, want 1", locked);
        end
        stream(40, 199, 1'b0, 1'b0);
        checks++;
        if (frame_err_cnt !== 16'd0 || seq_err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reanchor_errs: got ferr=%0d serr=%0d, want 0/0", frame_err_cnt, seq_err_cnt);
        end
    endtask

    task automatic test_seq();
        do_reset();
        stream(97, 128, 1'b0, 1'b0);
        dv = 16'h0200;
        stream(3, 128, 1'b0, 1'b0);          // 0200..0202, first seeds
        send_d(16'h0205, 2'b00, 1'b1);       // 0203 expected
        send_d(16'h0206, 2'b00, 1'b0);
        dv = 16'h0207;
        checks++;
        if (seq_err_cnt !== 16'd1) begin
            failures++;
            $display("FAIL seq_count1: got serr=%0d, want 1", seq_err_cnt);
        end
        idle();
        stream(10, 128, 1'b0, 1'b0);
        send_d(16'hffff, 2'b00, 1'b1);       // jump, reseed at ffff
        send_d(16'h0000, 2'b00, 1'b0);       // wrap is legal
        send_d(16'h0001, 2'b00, 1'b0);
        dv = 16'h0002;
        stream(20, 128, 1'b0, 1'b0);         // crosses a comma
        checks++;
        if (seq_err_cnt !== 16'd2 || frame_err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL seq_count2: got serr=%0d ferr=%0d, want 2/0", seq_err_cnt, frame_err_cnt);
        end
    endtask

    task automatic test_kerr_reset();
        do_reset();
        stream(165, 128, 1'b0, 1'b0);
        send_d(16'h1234, 2'b01, 1'b0);       // partial K at idx 5
        stream(26, 128, 1'b0, 1'b0);
        checks++;
        if (frame_err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL kerr_pre: got ferr=%0d, want 0", frame_err_cnt);
        end
        stream(1, 128, 1'b0, 1'b0);
        checks++;
        if (frame_err_cnt !== 16'd1 || locked !== 1'b1 || seq_err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL kerr_eval: got ferr=%0d locked=%b serr=%0d, want 1/1/0",
                     frame_err_cnt, locked, seq_err_cnt);
        end
        stream(5, 128, 1'b0, 1'b0);
        reset         = 1'b1;
        bus.rxdata    = dv;
        bus.rxcharisk = 2'b00;
        bus.rxstb     = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.rxstb = 1'b0;
        checks++;
        if ({bus.dout, bus.dout_stb, bus.sof, bus.word_idx, locked, state,
             frame_err_cnt, seq_err, seq_err_cnt} !== '0) begin
            failures++;
            $display("FAIL midframe_reset: got dout=%h stb=%b sof=%b idx=%0d locked=%b state=%0d ferr=%0d seq_err=%b serr=%0d, want 0",
                     bus.dout, bus.dout_stb, bus.sof, bus.word_idx, locked, state,
                     frame_err_cnt, seq_err, seq_err_cnt);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_clean(1'b0);
        test_clean(1'b1);
        test_drop_commas();
        test_reanchor();
        test_seq();
        test_kerr_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
